dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the CPU data port (port b: read_b/write_b/wmask_b/address_b/wdata_b, answered by resp_b/rdata_b).
- Serves a small on-chip word SRAM with a fixed, parameterised response latency.
- Also serves an optional MMIO window of transaction counters.
- Used as the data-port end in simulation and small FPGA builds, in place of the cache hierarchy.

Parameters:
- DEPTH_WORDS, 256, number of 16-bit SRAM words; power of two, minimum 2.
- LATENCY, 2, cycles from request acceptance to resp_b; minimum 1.
- MMIO_BASE, 16'hFF00, byte address of the counter window.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- read_b  input  1  read request; held by requester until resp_b.
- write_b  input  1  write request; held by requester until resp_b.
- wmask_b  input  2  byte enables; bit0 = bits 7:0, bit1 = bits 15:8.
- address_b  input  16  byte address; bit0 ignored for word select.
- wdata_b  input  16  write data.
- resp_b  output  1  one-cycle completion pulse.
- rdata_b  output  16  read data, valid in the resp_b cycle.
- err  output  1  sticky out-of-range access flag.

Behaviour:
- Reset (async): state IDLE, resp_b=0, rdata_b=0, err=0, counters=0. SRAM contents are not reset.
- Reset asserted mid-transaction aborts it: no SRAM write, no resp_b.
- FSM states: IDLE, WAIT, RESP.
- IDLE: if read_b|write_b, latch address/wdata/mask and op, load lat_cnt=LATENCY-1, then go to WAIT (LATENCY=1 goes directly to RESP).
- WAIT: decrement lat_cnt; go to RESP when it reaches 0.
- Timing: request accepted at cycle T gives resp_b=1 at exactly T+LATENCY.
- RESP: resp_b=1 for one cycle, the operation is performed, return to IDLE.
- A request still high in IDLE the cycle after RESP is accepted as a new transaction; back-to-back rate is one transaction per LATENCY+1 cycles.
- Request inputs are ignored outside IDLE. Latched values are used even if inputs change.
- read_b and write_b both high: treated as a write; rdata_b returns 0.
- Address decode: SRAM if address_b < 2*DEPTH_WORDS, word index = address_b[log2(DEPTH_WORDS):1].
- Write: update only the bytes enabled by the mask. wmask 00 makes no change but still responds.
- Read: rdata_b = SRAM word at the RESP cycle, so it includes all earlier writes. rdata_b is registered and holds its value until the next read response.
- Out of range (neither SRAM nor an enabled MMIO address): read returns 16'h0000, write is dropped, err sets and stays set until reset; resp_b still pulses.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: DMEM_PERF_CNT_EN.
- Defined:
  - rd_cnt at MMIO_BASE, wr_cnt at MMIO_BASE+2; both 16-bit, saturating at 16'hFFFF.
  - They increment on RESP of in-range SRAM reads and writes only. MMIO and out-of-range accesses are not counted.
  - MMIO read returns the counter value.
  - MMIO write with a nonzero mask clears the addressed counter, regardless of wdata.
  - Other addresses in the window are out of range.
- Undefined: no counters; the MMIO window is out of range like any other unmapped address.

Test Plan:
- Write 16'hBEEF, mask 11, addr 16'h0010; then read 16'h0010 -> resp_b at T+2 each time, rdata_b=16'hBEEF.
- After the above, write 16'h1234, mask 01, addr 16'h0011; read 16'h0010 -> 16'hBE34.
- Read 16'h2000 (out of range) -> resp_b at T+2, rdata_b=16'h0000, err=1 and stays 1 through later valid accesses.
- read_b held high continuously at addr 16'h0000 -> resp_b pulses every 3 cycles, never on consecutive cycles.
- Assert reset in the WAIT cycle of a write of 16'hAAAA to 16'h0020 -> no resp_b. A prior value of 16'h5555 there still reads back 16'h5555.
- With DMEM_PERF_CNT_EN: 3 SRAM reads and 2 SRAM writes, then read 16'hFF00 -> 3 and 16'hFF02 -> 2. Write 16'hFF00, mask 11 -> subsequent read of 16'hFF00 returns 0.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-port responder: word SRAM behind a fixed-latency IDLE/WAIT/RESP handshake.
// Optional MMIO transaction counters are compiled in with `define DMEM_PERF_CNT_EN.
module dmem_responder #(
    parameter int          DEPTH_WORDS = 256,
    parameter int          LATENCY     = 2,
    parameter logic [15:0] MMIO_BASE   = 16'hFF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read_b,
    input  logic        write_b,
    input  logic [1:0]  wmask_b,
    input  logic [15:0] address_b,
    input  logic [15:0] wdata_b,
    output logic        resp_b,
    output logic [15:0] rdata_b,
    output logic        err
);
    localparam int AW = (DEPTH_WORDS > 2) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] lat_q, lat_d;
    logic [15:0]   addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [1:0]    mask_q, mask_d;
    logic          rd_q, rd_d, wr_q, wr_d, resp_q, resp_d, err_q, err_d;
    logic          exec, mem_we, sram_hit, mmio_hit;
    logic [15:0]   mem [DEPTH_WORDS];

    // With LATENCY=1 the operation executes on the accepting edge, so it must
    // see the live request instead of the not-yet-latched copy.
    logic          from_idle;
    logic [15:0]   op_addr, op_wdata;
    logic [1:0]    op_mask;
    logic          op_rd, op_wr;
    logic [AW-1:0] word_idx;

    assign from_idle = (state_q == IDLE);
    assign op_addr   = from_idle ? address_b : addr_q;
    assign op_wdata  = from_idle ? wdata_b   : wdata_q;
    assign op_mask   = from_idle ? wmask_b   : mask_q;
    assign op_rd     = from_idle ? read_b    : rd_q;
    assign op_wr     = from_idle ? write_b   : wr_q;
    assign word_idx  = op_addr[AW:1];
    assign sram_hit  = ({1'b0, op_addr} < 17'(2 * DEPTH_WORDS));

`ifdef DMEM_PERF_CNT_EN
    localparam logic [15:0] WR_CNT_ADDR = MMIO_BASE + 16'd2;
    logic [15:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
    logic        sel_rd_cnt, sel_wr_cnt;
    assign sel_rd_cnt = !sram_hit && (op_addr[15:1] == MMIO_BASE[15:1]);
    assign sel_wr_cnt = !sram_hit && (op_addr[15:1] == WR_CNT_ADDR[15:1]);
    assign mmio_hit   = sel_rd_cnt || sel_wr_cnt;
`else
    assign mmio_hit   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        exec    = 1'b0;
        case (state_q)
            IDLE: if (read_b || write_b) begin
                addr_d  = address_b;
                wdata_d = wdata_b;
                mask_d  = wmask_b;
                rd_d    = read_b;
                wr_d    = write_b;
                if (LATENCY == 1) begin
                    state_d = RESP;
                    exec    = 1'b1;
                end else begin
                    state_d = WAIT;
                    lat_d   = CW'(LATENCY - 1);
                end
            end
            WAIT: begin
                lat_d = lat_q - CW'(1);
                if (lat_q == CW'(1)) begin
                    state_d = RESP;
                    exec    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        resp_d = exec;
    end

    // The access is carried out on the edge entering RESP so rdata_b is
    // already registered while resp_b is high.
    always_comb begin
        rdata_d  = rdata_q;
        err_d    = err_q;
        mem_we   = 1'b0;
`ifdef DMEM_PERF_CNT_EN
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
`endif
        if (exec) begin
            if (!sram_hit && !mmio_hit)
                err_d = 1'b1;
            if (op_wr) begin
                if (op_rd)
                    rdata_d = 16'h0000;
                if (sram_hit) begin
                    mem_we = 1'b1;
`ifdef DMEM_PERF_CNT_EN
                    if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
                end else if (op_mask != 2'b00) begin
                    if (sel_rd_cnt) rd_cnt_d = 16'h0000;
                    if (sel_wr_cnt) wr_cnt_d = 16'h0000;
`endif
                end
            end else if (sram_hit) begin
                rdata_d = mem[word_idx];
`ifdef DMEM_PERF_CNT_EN
                if (rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
            end else if (sel_rd_cnt) begin
                rdata_d = rd_cnt_q;
            end else if (sel_wr_cnt) begin
                rdata_d = wr_cnt_q;
`endif
            end else begin
                rdata_d = 16'h0000;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            lat_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            mask_q   <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            resp_q   <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
`ifdef DMEM_PERF_CNT_EN
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            mask_q   <= mask_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            resp_q   <= resp_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
`ifdef DMEM_PERF_CNT_EN
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
`endif
        end
    end

    // SRAM contents survive reset; byte lanes written independently.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            if (op_mask[0]) mem[word_idx][7:0]  <= op_wdata[7:0];
            if (op_mask[1]) mem[word_idx][15:8] <= op_wdata[15:8];
        end
    end

    assign resp_b  = resp_q;
    assign rdata_b = rdata_q;
    assign err     = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed plus randomized bench for dmem_responder against an array-based memory model.
module tb_dmem_responder;
    localparam int LAT   = 2;
    localparam int DEPTH = 256;
    localparam int IW    = $clog2(DEPTH);

    logic        clk = 1'b0;
    logic        reset;
    logic        read_b, write_b;
    logic [1:0]  wmask_b;
    logic [15:0] address_b, wdata_b;
    logic        resp_b;
    logic [15:0] rdata_b;
    logic        err;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .MMIO_BASE(16'hFF00)) dut (
        .clk(clk), .reset(reset), .read_b(read_b), .write_b(write_b),
        .wmask_b(wmask_b), .address_b(address_b), .wdata_b(wdata_b),
        .resp_b(resp_b), .rdata_b(rdata_b), .err(err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic [15:0] m_mem [DEPTH];
    bit          m_vld [DEPTH];
    logic [15:0] m_rdata;
    bit          m_rknown;
    bit          m_err;
    int          m_rd_cnt, m_wr_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference behaviour of one complete transaction.
    task automatic model(input bit rd, input bit wr, input logic [1:0] mask,
                         input logic [15:0] a, input logic [15:0] wd);
        int  idx;
        bit  in_sram, is_rc, is_wc;
        idx     = int'(a[IW:1]);
        in_sram = (int'(a) < 2 * DEPTH);
        is_rc   = 1'b0;
        is_wc   = 1'b0;
`ifdef DMEM_PERF_CNT_EN
        is_rc = !in_sram && (a[15:1] == 15'h7F80);
        is_wc = !in_sram && (a[15:1] == 15'h7F81);
`endif
        if (!in_sram && !is_rc && !is_wc) m_err = 1'b1;
        if (wr) begin
            if (rd) begin m_rdata = 16'h0000; m_rknown = 1'b1; end
            if (in_sram) begin
                if (mask[0]) m_mem[idx][7:0]  = wd[7:0];
                if (mask[1]) m_mem[idx][15:8] = wd[15:8];
                if (mask == 2'b11) m_vld[idx] = 1'b1;
                if (m_wr_cnt < 65535) m_wr_cnt++;
            end else if (mask != 2'b00) begin
                if (is_rc) m_rd_cnt = 0;
                if (is_wc) m_wr_cnt = 0;
            end
        end else if (rd) begin
            m_rknown = 1'b1;
            if (in_sram) begin
                m_rdata  = m_mem[idx];
                m_rknown = m_vld[idx];
                if (m_rd_cnt < 65535) m_rd_cnt++;
            end else if (is_rc) m_rdata = 16'(m_rd_cnt);
            else if (is_wc)     m_rdata = 16'(m_wr_cnt);
            else                m_rdata = 16'h0000;
        end
    endtask

    task automatic txn(input bit rd, input bit wr, input logic [1:0] mask,
                       input logic [15:0] a, input logic [15:0] wd, input string tag);
        int cyc;
        bit seen;
        @(negedge clk);
        read_b = rd; write_b = wr; wmask_b = mask; address_b = a; wdata_b = wd;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(posedge clk); @(negedge clk);
            cyc++;
            if (resp_b) seen = 1'b1;
            // Scramble inputs after acceptance; latched values must be used.
            address_b = 16'($urandom); wdata_b = 16'($urandom); wmask_b = 2'($urandom);
        end
        read_b = 1'b0; write_b = 1'b0;
        check({tag, "_lat"}, cyc, LAT);
        model(rd, wr, mask, a, wd);
        if (m_rknown) check({tag, "_rdata"}, rdata_b, m_rdata);
        check({tag, "_err"}, err, m_err);
        @(posedge clk); @(negedge clk);
        check({tag, "_pulse"}, resp_b, 1'b0);
    endtask

    task automatic model_reset();
        m_err = 1'b0; m_rdata = 16'h0000; m_rknown = 1'b1;
        m_rd_cnt = 0; m_wr_cnt = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        bit resp_seen;
        for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
        reset = 1'b1; read_b = 1'b0; write_b = 1'b0; wmask_b = 2'b00;
        address_b = 16'h0000; wdata_b = 16'h0000;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_resp", resp_b, 1'b0);
        check("rst_rdata", rdata_b, 16'h0000);
        check("rst_err", err, 1'b0);
        reset = 1'b0;

        txn(1'b0, 1'b1, 2'b11, 16'h0010, 16'hBEEF, "wr_beef");
        txn(1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000, "rd_beef");
        check("beef_value", rdata_b, 16'hBEEF);
        txn(1'b0, 1'b1, 2'b01, 16'h0011, 16'h1234, "wr_lo");
        txn(1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000, "rd_be34");
        check("be34_value", rdata_b, 16'hBE34);
        txn(1'b1, 1'b0, 2'b00, 16'h2000, 16'h0000, "rd_oor");
        check("oor_rdata", rdata_b, 16'h0000);
        check("oor_err", err, 1'b1);
        txn(1'b0, 1'b1, 2'b00, 16'h0010, 16'hFFFF, "wr_nomask");
        txn(1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000, "rd_after_nomask");
        check("err_sticky", err, 1'b1);
        txn(1'b1, 1'b1, 2'b11, 16'h0030, 16'h4321, "rdwr_both");
        check("both_rdata", rdata_b, 16'h0000);

        // Held read: one response every LAT+1 cycles.
        @(negedge clk);
        read_b = 1'b1; address_b = 16'h0000;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); @(negedge clk);
            check($sformatf("held_rd_c%0d", k), resp_b, (k % (LAT + 1)) == LAT);
        end
        read_b = 1'b0;
        model(1'b1, 1'b0, 2'b00, 16'h0000, 16'h0000);

        // Reset during WAIT aborts the write.
        txn(1'b0, 1'b1, 2'b11, 16'h0020, 16'h5555, "wr_5555");
        @(negedge clk);
        write_b = 1'b1; wmask_b = 2'b11; address_b = 16'h0020; wdata_b = 16'hAAAA;
        @(posedge clk); @(negedge clk);
        reset = 1'b1;
        resp_seen = resp_b;
        repeat (2) begin
            @(posedge clk); @(negedge clk);
            resp_seen = resp_seen | resp_b;
        end
        write_b = 1'b0; reset = 1'b0;
        model_reset();
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            resp_seen = resp_seen | resp_b;
        end
        check("abort_no_resp", resp_seen, 1'b0);
        check("abort_err_clr", err, 1'b0);
        check("abort_rdata", rdata_b, 16'h0000);
        txn(1'b1, 1'b0, 2'b00, 16'h0020, 16'h0000, "rd_5555");
        check("abort_kept", rdata_b, 16'h5555);

`ifdef DMEM_PERF_CNT_EN
        txn(1'b0, 1'b1, 2'b11, 16'hFF00, 16'h1234, "clr_rc");
        txn(1'b0, 1'b1, 2'b10, 16'hFF02, 16'h0000, "clr_wc");
        for (int i = 0; i < 3; i++) txn(1'b1, 1'b0, 2'b00, 16'h0010, 16'h0, "cnt_rd");
        for (int i = 0; i < 2; i++) txn(1'b0, 1'b1, 2'b11, 16'h0040, 16'(i), "cnt_wr");
        txn(1'b1, 1'b0, 2'b00, 16'hFF00, 16'h0000, "rd_rc");
        check("rd_cnt_3", rdata_b, 16'd3);
        txn(1'b1, 1'b0, 2'b00, 16'hFF02, 16'h0000, "rd_wc");
        check("wr_cnt_2", rdata_b, 16'd2);
        txn(1'b0, 1'b1, 2'b11, 16'hFF00, 16'hFFFF, "clr_rc2");
        txn(1'b1, 1'b0, 2'b00, 16'hFF00, 16'h0000, "rd_rc0");
        check("rd_cnt_clr", rdata_b, 16'd0);
        txn(1'b1, 1'b0, 2'b00, 16'hFF04, 16'h0000, "rd_win_oor");
        check("win_oor_err", err, 1'b1);
`else
        txn(1'b1, 1'b0, 2'b00, 16'hFF00, 16'h0000, "rd_mmio_off");
        check("mmio_off_err", err, 1'b1);
`endif

        for (int n = 0; n < 150; n++) begin
            int r;
            logic [15:0] a;
            r = int'($urandom_range(0, 9));
            a = (r == 9) ? 16'($urandom_range(16'h0200, 16'hFEFF))
                         : 16'($urandom_range(0, 2 * DEPTH - 1));
            txn(r < 4 || r >= 8, r >= 4 && r <= 8, 2'($urandom), a, 16'($urandom),
                $sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
